// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: round-robin front end that shares one FPU_Wrapper
// between NREQ requesters. One operation is outstanding at a time. The
// winner's fields are registered, issued to the FPU, and the result is
// returned over a per-requester valid/ready response channel.
// Optional feature macro: FPU_ARB_TIMEOUT_EN (WAIT watchdog, quiet-NaN abort).
`timescale 1ns/1ps
module fpu_req_arbiter #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  input  logic [NREQ*3-1:0]     req_operator,
  input  logic [NREQ*3-1:0]     req_rm,
  input  logic [NREQ*4-1:0]     req_tag,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_tag,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  fpu_in_valid,
  input  logic                  fpu_ready,
  output logic [WIDTH-1:0]      fpu_op1,
  output logic [WIDTH-1:0]      fpu_op2,
  output logic [2:0]            fpu_operator,
  output logic [2:0]            fpu_rm,
  output logic [3:0]            fpu_tag,
  output logic                  fpu_cpu_ready,
  input  logic                  fpu_result_valid,
  input  logic [3:0]            fpu_tag_out,
  input  logic [WIDTH-1:0]      fpu_result
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [2:0]         operator_q, operator_d;
  logic [2:0]         rm_q, rm_d;
  logic [3:0]         tag_q, tag_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic [3:0]         rsp_tag_q, rsp_tag_d;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand_idx;
  int unsigned        cand;
  logic [PTR_W-1:0]   owner_next;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] QNAN_ONES =
    {{(WIDTH-EXP_WIDTH-1){1'b0}}, {(EXP_WIDTH+1){1'b1}}};
  localparam logic [WIDTH-1:0] QNAN = QNAN_ONES << (WIDTH - EXP_WIDTH - 2);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  // Round-robin search of req_valid starting at ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand     = (32'(ptr_q) + i) % NREQ;
      cand_idx = PTR_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Grant is combinational in IDLE; held off while reset is asserted so
  // every output reads 0 during reset regardless of req_valid.
  always_comb begin
    req_ready = '0;
    if (reset && state_q == S_IDLE && grant_found) begin
      req_ready = ONE_HOT0 << grant_idx;
    end
  end

  // Next-state and datapath capture for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    operator_d   = operator_q;
    rm_d         = rm_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    owner_next   = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d    = grant_idx;
          op1_d      = req_op1[grant_idx*WIDTH +: WIDTH];
          op2_d      = req_op2[grant_idx*WIDTH +: WIDTH];
          operator_d = req_operator[grant_idx*3 +: 3];
          rm_d       = req_rm[grant_idx*3 +: 3];
          tag_d      = req_tag[grant_idx*4 +: 4];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fpu_ready) begin
          state_d = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        // A matching result takes priority over a coincident timeout.
        if (fpu_result_valid && fpu_tag_out == tag_q) begin
          rsp_result_d = fpu_result;
          rsp_tag_d    = fpu_tag_out;
          state_d      = S_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d = QNAN;
          rsp_tag_d    = tag_q;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d        = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          ptr_d   = owner_next;
          state_d = S_IDLE;
`ifdef FPU_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      operator_q   <= '0;
      rm_q         <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      operator_q   <= operator_d;
      rm_q         <= rm_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  // Outputs are registers or pure decodes of the registered state.
  always_comb begin
    busy          = (state_q != S_IDLE);
    fpu_in_valid  = (state_q == S_ISSUE);
    fpu_cpu_ready = (state_q == S_WAIT);
    rsp_valid     = (state_q == S_RESP) ? (ONE_HOT0 << owner_q) : '0;
    fpu_op1       = op1_q;
    fpu_op2       = op2_q;
    fpu_operator  = operator_q;
    fpu_rm        = rm_q;
    fpu_tag       = tag_q;
    rsp_result    = rsp_result_q;
    rsp_tag       = rsp_tag_q;
`ifdef FPU_ARB_TIMEOUT_EN
    rsp_err       = rsp_err_q;
`else
    rsp_err       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter with a scoreboard of expected responses
// and a behavioural FPU responder driven from the stimulus sequence.
`timescale 1ns/1ps
module tb_fpu_req_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned EXPW  = 8;
  localparam int unsigned TO    = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_op1, req_op2;
  logic [NREQ*3-1:0]     req_operator, req_rm;
  logic [NREQ*4-1:0]     req_tag;
  logic [NREQ-1:0]       rsp_valid, rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic [3:0]            rsp_tag;
  logic                  rsp_err, busy;
  logic                  fpu_in_valid, fpu_ready;
  logic [WIDTH-1:0]      fpu_op1, fpu_op2;
  logic [2:0]            fpu_operator, fpu_rm;
  logic [3:0]            fpu_tag;
  logic                  fpu_cpu_ready, fpu_result_valid;
  logic [3:0]            fpu_tag_out;
  logic [WIDTH-1:0]      fpu_result;

  fpu_req_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .EXP_WIDTH(EXPW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .req_operator(req_operator), .req_rm(req_rm), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy),
    .fpu_in_valid(fpu_in_valid), .fpu_ready(fpu_ready),
    .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
    .fpu_operator(fpu_operator), .fpu_rm(fpu_rm), .fpu_tag(fpu_tag),
    .fpu_cpu_ready(fpu_cpu_ready),
    .fpu_result_valid(fpu_result_valid), .fpu_tag_out(fpu_tag_out),
    .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned owner;
    logic [3:0]  tag;
    logic [31:0] result;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int unsigned exp_ptr = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int unsigned i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural FPU: exact for the 1.0 + 2.0 case, a fixed mix otherwise.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] opr);
    if (opr == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a + b) ^ {29'd0, opr};
  endfunction

  function automatic int unsigned model_winner();
    int unsigned c;
    for (int unsigned i = 0; i < NREQ; i++) begin
      c = (exp_ptr + i) % NREQ;
      if (req_valid[c]) return c;
    end
    return 0;
  endfunction

  task automatic set_req(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] opr, input logic [2:0] rm, input logic [3:0] tg);
    req_op1[r*WIDTH +: WIDTH] = a;
    req_op2[r*WIDTH +: WIDTH] = b;
    req_operator[r*3 +: 3]    = opr;
    req_rm[r*3 +: 3]          = rm;
    req_tag[r*4 +: 4]         = tg;
    req_valid[r]              = 1'b1;
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    check({name, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({name, "_rsp_valid"},  64'(rsp_valid),  64'(onehot(e.owner)));
      check({name, "_rsp_result"}, 64'(rsp_result), 64'(e.result));
      check({name, "_rsp_tag"},    64'(rsp_tag),    64'(e.tag));
      check({name, "_rsp_err"},    64'(rsp_err),    64'(e.err));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({req_ready, rsp_valid, rsp_err, busy, fpu_in_valid, fpu_cpu_ready}), 64'd0);
    check({name, "_data"}, 64'({rsp_result, rsp_tag, fpu_tag, fpu_operator, fpu_rm}), 64'd0);
    check({name, "_ops"},  64'({fpu_op1, fpu_op2}), 64'd0);
  endtask

  // One full transaction starting at a negedge with requests already driven.
  task automatic do_txn(input string name, input int unsigned issue_stall,
                        input int unsigned lat, input int unsigned rsp_stall,
                        input bit bad_tag, input bit keep);
    int unsigned w;
    exp_t        e;
    logic [31:0] s_op1, s_op2;
    logic [3:0]  s_tag;
    logic [2:0]  s_opr;
    #1;
    w      = model_winner();
    s_op1  = req_op1[w*WIDTH +: WIDTH];
    s_op2  = req_op2[w*WIDTH +: WIDTH];
    s_opr  = req_operator[w*3 +: 3];
    s_tag  = req_tag[w*4 +: 4];
    check({name, "_grant"}, 64'(req_ready), 64'(onehot(w)));
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
    e.owner  = w;
    e.tag    = s_tag;
    e.result = fpu_fn(s_op1, s_op2, s_opr);
    e.err    = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) req_valid[w] = 1'b0;
    check({name, "_in_valid"}, 64'(fpu_in_valid), 64'd1);
    check({name, "_fpu_ops"},  64'({fpu_op1, fpu_op2}), 64'({s_op1, s_op2}));
    check({name, "_fpu_ctl"},  64'({fpu_operator, fpu_rm, fpu_tag}),
          64'({s_opr, req_rm[w*3 +: 3], s_tag}));
    check({name, "_no_grant_issue"}, 64'(req_ready), 64'd0);
    for (int unsigned i = 0; i < issue_stall; i++) begin
      @(negedge clk);
      check({name, "_stall_valid"}, 64'(fpu_in_valid), 64'd1);
      check({name, "_stall_ops"},   64'({fpu_op1, fpu_op2}), 64'({s_op1, s_op2}));
    end
    fpu_ready = 1'b1;
    @(negedge clk);
    fpu_ready = 1'b0;
    check({name, "_wait_state"}, 64'({fpu_in_valid, fpu_cpu_ready}), 64'(2'b01));
    for (int unsigned i = 0; i < lat; i++) begin
      @(negedge clk);
      check({name, "_wait_hold"}, 64'({fpu_cpu_ready, rsp_valid}), 64'({1'b1, {NREQ{1'b0}}}));
    end
    if (bad_tag) begin
      fpu_result_valid = 1'b1;
      fpu_tag_out      = 4'hA;
      fpu_result       = 32'hDEAD_BEEF;
      @(negedge clk);
      fpu_result_valid = 1'b0;
      check({name, "_mismatch_ignored"}, 64'({fpu_cpu_ready, rsp_valid}), 64'({1'b1, {NREQ{1'b0}}}));
    end
    fpu_result_valid = 1'b1;
    fpu_tag_out      = fpu_tag;
    fpu_result       = fpu_fn(fpu_op1, fpu_op2, fpu_operator);
    @(negedge clk);
    fpu_result_valid = 1'b0;
    fpu_result       = '0;
    check_rsp(name);
    rsp_ready = ~onehot(w);
    for (int unsigned i = 0; i < rsp_stall; i++) begin
      @(negedge clk);
      check({name, "_rsp_hold"}, 64'({rsp_valid, rsp_result}), 64'({onehot(w), e.result}));
      check({name, "_no_grant_resp"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = onehot(w);
    @(negedge clk);
    rsp_ready = '0;
    check({name, "_back_idle"}, 64'({rsp_valid, busy}), 64'd0);
    exp_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0;
    req_operator = '0; req_rm = '0; req_tag = '0; rsp_ready = '0;
    fpu_ready = 1'b0; fpu_result_valid = 1'b0; fpu_tag_out = '0; fpu_result = '0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Single add: 1.0 + 2.0 from requester 0, tag 5.
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 4'h5);
    do_txn("add", 0, 2, 0, 1'b0, 1'b0);

    // Backpressure on both handshakes; requester 0 waits throughout.
    set_req(1, 32'h1234_5678, 32'h0BAD_F00D, 3'd1, 3'd2, 4'h7);
    set_req(0, 32'h4120_0000, 32'h3F00_0000, 3'd4, 3'd1, 4'h3);
    do_txn("bp", 5, 3, 3, 1'b0, 1'b0);

    // Tag mismatch: requester 0 issued with tag 3, bogus tag 0xA injected.
    do_txn("tagmis", 0, 1, 0, 1'b1, 1'b0);

    // Bring ptr back to 0 with one requester-1 operation.
    set_req(1, 32'hC000_0000, 32'h4080_0000, 3'd2, 3'd1, 4'h9);
    do_txn("mul", 0, 4, 0, 1'b0, 1'b0);

    // Fairness: both hold req_valid; grant order 0,1,0,1 then back to 0.
    set_req(0, 32'h0000_1111, 32'h0000_2222, 3'd1, 3'd0, 4'h1);
    set_req(1, 32'h3333_0000, 32'h4444_0000, 3'd3, 3'd2, 4'h2);
    do_txn("fair0", 0, 1, 0, 1'b0, 1'b1);
    do_txn("fair1", 0, 2, 1, 1'b0, 1'b1);
    do_txn("fair2", 1, 1, 0, 1'b0, 1'b1);
    do_txn("fair3", 0, 3, 0, 1'b0, 1'b1);
    do_txn("fair4", 0, 1, 0, 1'b0, 1'b0);

    // Reset in WAIT: requester 1 owns, ptr would be 1 without the reset.
    #1;
    check("mid_grant", 64'(req_ready), 64'(2'b10));
    @(negedge clk);
    check("mid_issue", 64'(fpu_in_valid), 64'd1);
    fpu_ready = 1'b1;
    @(negedge clk);
    fpu_ready = 1'b0;
    check("mid_in_wait", 64'(fpu_cpu_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midwait_reset");
    reset   = 1'b1;
    exp_ptr = 0;
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 4'hC);
    do_txn("post_rst0", 1, 2, 1, 1'b0, 1'b0);
    do_txn("post_rst1", 0, 1, 0, 1'b0, 1'b0);

`ifdef FPU_ARB_TIMEOUT_EN
    begin
      int unsigned k;
      exp_t        e;
      set_req(1, 32'h5555_5555, 32'h6666_6666, 3'd0, 3'd0, 4'h6);
      #1;
      check("to_grant", 64'(req_ready), 64'(2'b10));
      e.owner = 1; e.tag = 4'h6; e.result = 32'h7FC0_0000; e.err = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      req_valid = '0;
      fpu_ready = 1'b1;
      @(negedge clk);
      fpu_ready = 1'b0;
      k = 0;
      while (rsp_valid == '0 && k < TO + 8) begin
        @(negedge clk);
        k++;
      end
      check("to_latency", 64'(k), 64'(TO));
      check_rsp("timeout");
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = '0;
      check("to_err_clear", 64'({rsp_err, busy}), 64'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
